// File: rtl/capi_command_arbiter_pkg.sv
// Shared CAPI/PSL command and response types plus arbiter state and parity helper.
// Imported by the command arbiter and its tag pool.
package capi_command_arbiter_pkg;

   localparam int DEFAULT_NUM_TAGS = 32;

   typedef enum logic [12:0] {
      INVALID    = 13'h0000,
      RESTART    = 13'h0001,
      READ_CL_NA = 13'h0A00,
      WRITE_NA   = 13'h0D00
   } afu_command_t;

   typedef enum logic [7:0] {
      DONE    = 8'h00,
      AERROR  = 8'h01,
      DERROR  = 8'h03,
      NLOCK   = 8'h04,
      NRES    = 8'h05,
      FLUSHED = 8'h06,
      FAULT   = 8'h07,
      FAILED  = 8'h08,
      PAGED   = 8'h0A
   } psl_response_t;

   typedef enum logic [2:0] {
      ABT_STRICT = 3'b000,
      ABT_ABORT  = 3'b001,
      ABT_PAGE   = 3'b010,
      ABT_PREF   = 3'b011,
      ABT_SPEC   = 3'b111
   } psl_abt_t;

   typedef struct packed {
      logic [7:0] room;
   } CommandInterfaceInput;

   typedef struct packed {
      logic          valid;
      logic [7:0]    tag;
      logic          tag_parity;
      afu_command_t  command;
      logic          command_parity;
      psl_abt_t      abt;
      logic [63:0]   address;
      logic          address_parity;
      logic [15:0]   context_handle;
      logic [11:0]   size;
   } CommandInterfaceOutput;

   typedef struct packed {
      logic          valid;
      logic [7:0]    tag;
      psl_response_t response;
      logic [8:0]    credits;
   } ResponseInterface;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      RESTART_ISSUE,
      RESTART_WAIT
   } arb_state_t;

   // Owner table encoding: bit 1 = tag belongs to a requester, bit 0 = requester index.
   localparam logic [1:0] OWNER_NONE = 2'b00;

   // Odd parity: the data bits plus the returned bit hold an odd number of ones.
   function automatic logic odd_parity(input logic [63:0] data);
      return ~(^data);
   endfunction

endpackage

// File: rtl/capi_command_arbiter_tag_pool.sv
// Tag pool: busy bitmap, lowest-free-tag encoder, per-tag owner table and busy count.
// Allocation and release take effect at the clock edge; lookups see registered state only.
module capi_tag_pool
   import capi_command_arbiter_pkg::*;
#(
   parameter int NUM_TAGS = DEFAULT_NUM_TAGS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_alloc,
   input  logic [1:0] i_alloc_owner,
   input  logic       i_free,
   input  logic [7:0] i_rsp_tag,
   output logic       o_free_valid,
   output logic [7:0] o_free_tag,
   output logic       o_lookup_hit,
   output logic [1:0] o_lookup_owner,
   output logic [8:0] o_count
);

   localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

   logic [NUM_TAGS-1:0] r_busy;
   logic [1:0]          r_owner [NUM_TAGS];

   logic             w_in_range;
   logic [TAG_W-1:0] w_rsp_idx;
   logic [TAG_W-1:0] w_alloc_idx;

   assign w_in_range     = ({1'b0, i_rsp_tag} < 9'(NUM_TAGS));
   assign w_rsp_idx      = i_rsp_tag[TAG_W-1:0];
   assign w_alloc_idx    = o_free_tag[TAG_W-1:0];
   assign o_lookup_hit   = w_in_range && r_busy[w_rsp_idx];
   assign o_lookup_owner = r_owner[w_rsp_idx];

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      o_free_valid = 1'b0;
      o_free_tag   = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            o_free_valid = 1'b1;
            o_free_tag   = 8'(i);
         end
      end
   end

   always_comb begin
      o_count = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         o_count = o_count + 9'(r_busy[i]);
      end
   end

   // NOTE: the owner table is a handful of flops, so it is reset with the bitmap; a RAM-style
   // table would not be, since the busy bitmap alone decides whether an entry is meaningful.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy <= '0;
         for (int i = 0; i < NUM_TAGS; i++) begin
            r_owner[i] <= OWNER_NONE;
         end
      end else begin
         if (i_alloc) begin
            r_busy[w_alloc_idx]  <= 1'b1;
            r_owner[w_alloc_idx] <= i_alloc_owner;
         end
         if (i_free && o_lookup_hit) begin
            r_busy[w_rsp_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/capi_command_arbiter.sv
// Two-requester PSL command arbiter: round-robin grant, credit and tag tracking,
// response routing and RESTART handling after a PAGED response.
module capi_command_arbiter
   import capi_command_arbiter_pkg::*;
#(
   parameter int NUM_TAGS = DEFAULT_NUM_TAGS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  CommandInterfaceInput        command_in,
   input  logic [15:0]                 context_handle,
   input  logic [1:0]                  req_valid,
   input  afu_command_t [1:0]          req_command,
   input  logic [1:0][63:0]            req_address,
   input  logic [1:0][11:0]            req_size,
   output logic [1:0]                  req_ready,
   output CommandInterfaceOutput       command_out,
   input  ResponseInterface            response_in,
   output logic [1:0]                  rsp_valid,
   output psl_response_t               rsp_response,
   output logic [8:0]                  outstanding,
   output logic                        tag_error
);

   arb_state_t r_state;
   logic [8:0] r_credits;
   logic [8:0] r_credit_max;
   logic       r_rr_priority;
   logic [7:0] r_restart_tag;

   logic       w_free_valid;
   logic [7:0] w_free_tag;
   logic       w_hit;
   logic [1:0] w_hit_owner;
   logic       w_can_issue;
   logic       w_grant;
   logic       w_grant_sel;
   logic       w_restart_issue;
   logic       w_alloc;
   logic [1:0] w_alloc_owner;
   logic       w_rsp_hit;
   logic [9:0] w_credit_sum;
   logic [8:0] w_credits_next;

   assign w_can_issue     = (r_credits != '0) && w_free_valid;
   assign w_grant         = !reset && (r_state == RUN) && w_can_issue && (|req_valid);
   // On a tie the pointer decides; otherwise whichever requester is valid wins.
   assign w_grant_sel     = (&req_valid) ? r_rr_priority : req_valid[1];
   assign w_restart_issue = (r_state == RESTART_ISSUE) && w_can_issue;
   assign w_alloc         = w_grant || w_restart_issue;
   assign w_alloc_owner   = w_restart_issue ? OWNER_NONE : {1'b1, w_grant_sel};
   assign w_rsp_hit       = response_in.valid && w_hit;

   assign req_ready[0] = w_grant && !w_grant_sel;
   assign req_ready[1] = w_grant && w_grant_sel;

   // Net credit change for the cycle, clamped to the room seen at INIT.
   always_comb begin
      w_credit_sum   = 10'(r_credits) - 10'(w_alloc)
                     + (response_in.valid ? 10'(response_in.credits) : 10'd0);
      w_credits_next = (w_credit_sum > 10'(r_credit_max)) ? r_credit_max : w_credit_sum[8:0];
   end

   capi_tag_pool #(
      .NUM_TAGS (NUM_TAGS)
   ) u_tag_pool (
      .clock          (clock),
      .reset          (reset),
      .i_alloc        (w_alloc),
      .i_alloc_owner  (w_alloc_owner),
      .i_free         (response_in.valid),
      .i_rsp_tag      (response_in.tag),
      .o_free_valid   (w_free_valid),
      .o_free_tag     (w_free_tag),
      .o_lookup_hit   (w_hit),
      .o_lookup_owner (w_hit_owner),
      .o_count        (outstanding)
   );

   // NOTE: all state here is sequential and uses non-blocking assignments so every read
   // within this block sees the value from before the clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= INIT;
         r_credits     <= '0;
         r_credit_max  <= '0;
         r_rr_priority <= 1'b0;
         r_restart_tag <= '0;
         tag_error     <= 1'b0;
         command_out   <= '0;
         rsp_valid     <= '0;
         rsp_response  <= DONE;
      end else begin
         command_out <= '0;
         if (w_grant) begin
            command_out.valid          <= 1'b1;
            command_out.tag            <= w_free_tag;
            command_out.tag_parity     <= odd_parity(64'(w_free_tag));
            command_out.command        <= req_command[w_grant_sel];
            command_out.command_parity <= odd_parity(64'(req_command[w_grant_sel]));
            command_out.abt            <= ABT_STRICT;
            command_out.address        <= req_address[w_grant_sel];
            command_out.address_parity <= odd_parity(req_address[w_grant_sel]);
            command_out.context_handle <= context_handle;
            command_out.size           <= req_size[w_grant_sel];
            r_rr_priority              <= ~w_grant_sel;
         end else if (w_restart_issue) begin
            command_out.valid          <= 1'b1;
            command_out.tag            <= w_free_tag;
            command_out.tag_parity     <= odd_parity(64'(w_free_tag));
            command_out.command        <= RESTART;
            command_out.command_parity <= odd_parity(64'(RESTART));
            command_out.abt            <= ABT_STRICT;
            command_out.address_parity <= odd_parity(64'd0);
            command_out.context_handle <= context_handle;
         end

         rsp_valid <= '0;
         if (w_rsp_hit && w_hit_owner[1]) begin
            rsp_valid[w_hit_owner[0]] <= 1'b1;
            rsp_response              <= response_in.response;
         end
         if (response_in.valid && !w_hit) begin
            tag_error <= 1'b1;
         end

         case (r_state)
            INIT: begin
               r_credits    <= 9'(command_in.room);
               r_credit_max <= 9'(command_in.room);
               r_state      <= RUN;
            end
            RUN: begin
               r_credits <= w_credits_next;
               if (w_rsp_hit && (response_in.response == PAGED)) begin
                  r_state <= RESTART_ISSUE;
               end
            end
            RESTART_ISSUE: begin
               r_credits <= w_credits_next;
               if (w_restart_issue) begin
                  r_restart_tag <= w_free_tag;
                  r_state       <= RESTART_WAIT;
               end
            end
            RESTART_WAIT: begin
               r_credits <= w_credits_next;
               if (w_rsp_hit && (response_in.tag == r_restart_tag)) begin
                  r_state <= (response_in.response == DONE) ? RUN : RESTART_ISSUE;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_capi_command_arbiter.sv
// Directed bench for capi_command_arbiter: inputs change on the falling edge and
// outputs are compared between edges against hand-computed values.
module tb_capi_command_arbiter;
   import capi_command_arbiter_pkg::*;

   logic                  clock;
   logic                  reset;
   CommandInterfaceInput  command_in;
   logic [15:0]           context_handle;
   logic [1:0]            req_valid;
   afu_command_t [1:0]    req_command;
   logic [1:0][63:0]      req_address;
   logic [1:0][11:0]      req_size;
   logic [1:0]            req_ready;
   CommandInterfaceOutput command_out;
   ResponseInterface      response_in;
   logic [1:0]            rsp_valid;
   psl_response_t         rsp_response;
   logic [8:0]            outstanding;
   logic                  tag_error;

   int n_vec;
   int n_err;

   capi_command_arbiter #(
      .NUM_TAGS (32)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .command_in     (command_in),
      .context_handle (context_handle),
      .req_valid      (req_valid),
      .req_command    (req_command),
      .req_address    (req_address),
      .req_size       (req_size),
      .req_ready      (req_ready),
      .command_out    (command_out),
      .response_in    (response_in),
      .rsp_valid      (rsp_valid),
      .rsp_response   (rsp_response),
      .outstanding    (outstanding),
      .tag_error      (tag_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
   endtask

   task automatic respond(input logic [7:0] tag, input psl_response_t rsp, input logic [8:0] cred);
      response_in.valid    = 1'b1;
      response_in.tag      = tag;
      response_in.response = rsp;
      response_in.credits  = cred;
   endtask

   task automatic no_response();
      response_in = '0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset           = 1'b1;
      command_in.room = 8'd4;
      context_handle  = 16'hBEEF;
      req_valid       = 2'b00;
      req_command[0]  = READ_CL_NA;
      req_command[1]  = WRITE_NA;
      req_address[0]  = 64'h1000;
      req_address[1]  = 64'h3;
      req_size[0]     = 12'd128;
      req_size[1]     = 12'd64;
      response_in     = '0;

      // Reset values
      cyc();
      cyc();
      #1;
      check("rst_cmd_valid", 64'(command_out.valid), 0);
      check("rst_cmd_command", 64'(command_out.command), 0);
      check("rst_req_ready", 64'(req_ready), 0);
      check("rst_rsp_valid", 64'(rsp_valid), 0);
      check("rst_rsp_response", 64'(rsp_response), 0);
      check("rst_outstanding", 64'(outstanding), 0);
      check("rst_tag_error", 64'(tag_error), 0);
      reset = 1'b0;
      cyc();   // INIT loaded room=4

      // Requester 0 alone, room 4: four issues on tags 0..3, then no more grants
      req_valid = 2'b01;
      for (int c = 0; c < 6; c++) begin
         #1;
         check("room4_ready", 64'(req_ready), (c < 4) ? 1 : 0);
         check("room4_cmd_valid", 64'(command_out.valid), (c >= 1 && c <= 4) ? 1 : 0);
         if (c >= 1 && c <= 4) check("room4_cmd_tag", 64'(command_out.tag), 64'(c - 1));
         if (c == 1) begin
            check("par_tag0", 64'(command_out.tag_parity), 1);
            check("par_cmd_read", 64'(command_out.command_parity), 1);
            check("par_addr_1000", 64'(command_out.address_parity), 0);
            check("cmd_abt", 64'(command_out.abt), 0);
            check("cmd_ctx", 64'(command_out.context_handle), 64'hBEEF);
            check("cmd_size0", 64'(command_out.size), 128);
         end
         if (c == 4) check("par_tag3", 64'(command_out.tag_parity), 1);
         cyc();
      end
      check("room4_outstanding", 64'(outstanding), 4);

      // Credits at 0: response credit and request in the same cycle -> grant one cycle later
      respond(8'd0, DONE, 9'd1);
      #1;
      check("cred0_same_cycle_ready", 64'(req_ready), 0);
      cyc();
      no_response();
      #1;
      check("cred0_next_cycle_ready", 64'(req_ready), 1);
      check("tag0_rsp_valid", 64'(rsp_valid), 1);
      check("tag0_rsp_response", 64'(rsp_response), 64'(DONE));
      check("tag0_freed_outstanding", 64'(outstanding), 3);
      cyc();
      #1;
      check("regrant_cmd_valid", 64'(command_out.valid), 1);
      check("regrant_cmd_tag", 64'(command_out.tag), 0);
      check("regrant_outstanding", 64'(outstanding), 4);
      check("regrant_then_ready", 64'(req_ready), 0);

      // Unallocated tag 17: tag_error, no routing, credit still returned
      respond(8'd17, DONE, 9'd1);
      cyc();
      no_response();
      #1;
      check("tag17_error", 64'(tag_error), 1);
      check("tag17_rsp_valid", 64'(rsp_valid), 0);
      check("tag17_credit_ready", 64'(req_ready), 1);
      cyc();
      #1;
      check("tag17_cmd_tag", 64'(command_out.tag), 4);
      check("tag17_outstanding", 64'(outstanding), 5);
      check("tag17_then_ready", 64'(req_ready), 0);
      req_valid = 2'b00;

      // PAGED on tag 2: forwarded, RESTART issued, grants blocked until its DONE
      respond(8'd2, PAGED, 9'd3);
      cyc();
      no_response();
      req_valid = 2'b01;
      #1;
      check("paged_rsp_valid", 64'(rsp_valid), 1);
      check("paged_rsp_response", 64'(rsp_response), 64'(PAGED));
      check("paged_outstanding", 64'(outstanding), 4);
      check("paged_block_ready", 64'(req_ready), 0);
      cyc();
      #1;
      check("restart_cmd_valid", 64'(command_out.valid), 1);
      check("restart_cmd_command", 64'(command_out.command), 64'(RESTART));
      check("restart_cmd_tag", 64'(command_out.tag), 2);
      check("restart_outstanding", 64'(outstanding), 5);
      check("restart_wait_ready", 64'(req_ready), 0);
      cyc();
      #1;
      check("restart_wait_ready2", 64'(req_ready), 0);
      check("restart_single_cmd", 64'(command_out.valid), 0);
      respond(8'd2, DONE, 9'd0);
      cyc();
      no_response();
      #1;
      check("restart_done_no_owner", 64'(rsp_valid), 0);
      check("restart_done_outstanding", 64'(outstanding), 4);
      check("resume_ready", 64'(req_ready), 1);
      cyc();
      #1;
      check("resume_cmd_tag", 64'(command_out.tag), 2);
      check("resume_cmd_command", 64'(command_out.command), 64'(READ_CL_NA));
      check("resume_outstanding", 64'(outstanding), 5);
      req_valid = 2'b00;

      // Leave three tags outstanding, then reset mid-operation with room 64
      respond(8'd3, DONE, 9'd1);
      cyc();
      respond(8'd4, DONE, 9'd1);
      cyc();
      no_response();
      #1;
      check("pre_reset_outstanding", 64'(outstanding), 3);
      command_in.room = 8'd64;
      reset     = 1'b1;
      req_valid = 2'b01;
      cyc();
      #1;
      check("midrst_outstanding", 64'(outstanding), 0);
      check("midrst_cmd_valid", 64'(command_out.valid), 0);
      check("midrst_tag_error", 64'(tag_error), 0);
      check("midrst_req_ready", 64'(req_ready), 0);
      reset     = 1'b0;
      req_valid = 2'b00;
      respond(8'd1, DONE, 9'd0);
      cyc();
      no_response();
      #1;
      check("abandoned_tag_error", 64'(tag_error), 1);
      check("abandoned_rsp_valid", 64'(rsp_valid), 0);

      // Both requesters for 6 cycles with room 64: grants alternate 0,1,...
      req_valid = 2'b11;
      for (int c = 0; c < 7; c++) begin
         if (c == 6) req_valid = 2'b00;
         #1;
         check("rr_ready", 64'(req_ready), (c == 6) ? 0 : ((c % 2 == 0) ? 1 : 2));
         check("rr_cmd_valid", 64'(command_out.valid), (c >= 1) ? 1 : 0);
         if (c >= 1) begin
            check("rr_cmd_tag", 64'(command_out.tag), 64'(c - 1));
            check("rr_cmd_command", 64'(command_out.command),
                  ((c - 1) % 2 == 0) ? 64'(READ_CL_NA) : 64'(WRITE_NA));
         end
         if (c == 2) begin
            check("par_addr_3", 64'(command_out.address_parity), 1);
            check("cmd_size1", 64'(command_out.size), 64);
         end
         cyc();
      end
      #1;
      check("rr_outstanding", 64'(outstanding), 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/capi_command_arbiter.md
CAPI_COMMAND_ARBITER -- requirements
Module: capi_command_arbiter

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 32, meaning the number of concurrently outstanding PSL commands (power of 2, max 256).
REQ-002 SHALL have port clock, input, 1, the single PSL clock.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port command_in, input, CommandInterfaceInput, carrying PSL command room.
REQ-005 SHALL have port context_handle, input, 16, driven onto every issued command.
REQ-006 SHALL have port req_valid, input, 2, per-requester request (0=read engine, 1=write engine).
REQ-007 SHALL have port req_command, input, 2 x afu_command_t, per-requester command code.
REQ-008 SHALL have port req_address, input, 2 x 64, per-requester effective address.
REQ-009 SHALL have port req_size, input, 2 x 12, per-requester transfer size.
REQ-010 SHALL have port req_ready, output, 2, per-requester grant.
REQ-011 SHALL have port command_out, output, CommandInterfaceOutput, registered command to PSL.
REQ-012 SHALL have port response_in, input, ResponseInterface, PSL response.
REQ-013 SHALL have port rsp_valid, output, 2, per-requester response strobe.
REQ-014 SHALL have port rsp_response, output, psl_response_t, forwarded response code.
REQ-015 SHALL have port outstanding, output, 9, count of allocated tags.
REQ-016 SHALL have port tag_error, output, 1, sticky flag for a response carrying an unallocated tag.

Function
REQ-017 SHALL implement states INIT, RUN, RESTART_ISSUE and RESTART_WAIT.
REQ-018 SHALL, in INIT (first cycle after reset), load credits := command_in.room and go to RUN.
REQ-019 SHALL, in RUN, grant at most one requester per cycle when credits>0, a free tag exists and req_valid is set.
REQ-020 SHALL resolve simultaneous requests round-robin; the last-granted requester loses ties, and requester 0 wins after reset.
REQ-021 SHALL make req_ready combinational and assert it only in the grant cycle; a transfer occurs on req_valid&&req_ready.
REQ-022 SHALL drive a granted request onto command_out in the next cycle with valid=1 for exactly one cycle, the lowest-index free tag, abt=STRICT and context_handle.
REQ-023 SHALL generate odd parity for tag_parity, command_parity and address_parity.
REQ-024 SHALL decrement credits by 1 on each issue and add response_in.credits on each valid response, saturating at the INIT value; the same-cycle net result is applied.
REQ-025 SHALL never let credits go below 0; no issue occurs when credits==0.
REQ-026 SHALL free a tag on a valid response; a tag freed in cycle N is allocatable from cycle N+1 only.
REQ-027 SHALL route a response one cycle after response_in.valid: rsp_valid[owner]=1 and rsp_response=response.
REQ-028 SHALL ignore a response whose tag is not allocated except for setting tag_error; in that case credits are still added.
REQ-029 SHALL, on a PAGED response, forward it to the owner, enter RESTART_ISSUE and block all grants.
REQ-030 SHALL, in RESTART_ISSUE with credits>0 and a free tag, issue a RESTART command with no owner and go to RESTART_WAIT.
REQ-031 SHALL, in RESTART_WAIT, return to RUN on the RESTART tag's response; if that response is not DONE, reissue via RESTART_ISSUE.
REQ-032 SHALL absorb additional PAGED responses while not in RUN without re-entering RESTART.
REQ-033 SHALL drive outstanding equal to the population count of allocated tags, including the RESTART tag.

Reset
REQ-034 SHALL, on reset, clear credits, the tag bitmap, the owner table, tag_error and the round-robin pointer, and enter INIT.
REQ-035 SHALL drive command_out.valid=0, all command_out fields=0, command=INVALID, req_ready=0, rsp_valid=0, rsp_response=DONE and outstanding=0 during reset.
REQ-036 SHALL, on reset mid-operation, abandon all in-flight tags; subsequent responses for those tags set tag_error.

Structure
REQ-037 SHALL place the state enum, the NUM_TAGS default and an odd-parity function in a shared package beside the CAPI types.
REQ-038 SHALL use one sub-module, capi_tag_pool, for the free bitmap, lowest-free-index encoder, owner table and popcount.

Verification
REQ-039 SHALL cover: room=4, requester 0 continuous with no responses -> exactly 4 commands with tags 0,1,2,3, then req_ready=0.
REQ-040 SHALL cover: both requesters valid for 6 cycles, room=64 -> grants alternate 0,1,0,1,0,1 and command_out lags each grant by 1 cycle.
REQ-041 SHALL cover: credits=0 with a response carrying credits=1 and a request in the same cycle -> issue occurs in the next cycle, not the same one.
REQ-042 SHALL cover: PAGED on tag 2 -> owner gets rsp_response=PAGED, a RESTART is issued, grants resume only after the DONE for the RESTART tag.
REQ-043 SHALL cover: a response on unallocated tag 17 -> tag_error=1, no rsp_valid, credits +1.
REQ-044 SHALL cover: reset asserted with 3 tags outstanding -> outstanding=0 next cycle and INIT reloads room.
